// File: rtl/timer_apb_seq.sv
// timer_apb_seq: APB master that programs a timer, polls its status register and reports overflow/underflow events
module timer_apb_seq #(
  parameter int POLL_GAP = 4,
  parameter int MAX_POLLS = 255
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] load_val,
  input  logic       cfg_up,
  input  logic [1:0] cfg_cks,
  input  logic       periodic,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [7:0] paddr,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pready,
  input  logic       pslverr,
  output logic       busy,
  output logic       evt_ovf,
  output logic       evt_udf,
  output logic       err,
  output logic [7:0] err_addr,
  output logic [7:0] evt_cnt
);
  typedef enum logic [2:0] {IDLE, WR_TDR, WR_LOAD, WR_RUN, GAP, POLL, CLR, WR_STOP} state_t;
  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);
  localparam logic [7:0] POLL_LAST = 8'(MAX_POLLS - 1);
  state_t state, state_nx;
  logic acc, up, per, stop_pend, xfer, done, ok, stop_any, timeout, unused_bits;
  logic [1:0] cks, flags;
  logic [7:0] ld, poll_cnt, gap_cnt;
  assign xfer = state != IDLE && state != GAP;
  assign done = xfer && acc && pready;
  assign ok = done && !pslverr;
  assign stop_any = stop || stop_pend;
  assign timeout = state == POLL && ok && prdata[1:0] == 2'b00 && poll_cnt == POLL_LAST;
  assign unused_bits = ^prdata[7:2];
  always_ff @(posedge pclk) begin
    if (preset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? WR_TDR : IDLE;
      WR_TDR:  state_nx = done ? (pslverr ? IDLE : WR_LOAD) : WR_TDR;
      WR_LOAD: state_nx = done ? (pslverr ? IDLE : WR_RUN) : WR_LOAD;
      WR_RUN:  state_nx = done ? (pslverr ? IDLE : GAP) : WR_RUN;
      GAP:     state_nx = stop_any ? WR_STOP : gap_cnt == GAP_LAST ? POLL : GAP;
      POLL:    state_nx = !done ? POLL : pslverr ? IDLE : (timeout || stop_any) ? WR_STOP :
                          prdata[1:0] != 2'b00 ? CLR : GAP;
      CLR:     state_nx = !done ? CLR : pslverr ? IDLE : (per && !stop_any) ? GAP : WR_STOP;
      WR_STOP: state_nx = done ? IDLE : WR_STOP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge pclk) begin
    if (preset) begin
      acc <= 1'b0;
      stop_pend <= 1'b0;
      poll_cnt <= 8'h00;
      gap_cnt <= 8'h00;
      flags <= 2'b00;
      evt_ovf <= 1'b0;
      evt_udf <= 1'b0;
      err <= 1'b0;
      err_addr <= 8'h00;
      evt_cnt <= 8'h00;
      ld <= 8'h00;
      up <= 1'b0;
      cks <= 2'b00;
      per <= 1'b0;
    end else begin
      acc <= xfer && !done;
      gap_cnt <= state == GAP ? gap_cnt + 8'd1 : 8'd0;
      evt_ovf <= state == CLR && ok && flags[0];
      evt_udf <= state == CLR && ok && flags[1];
      if (state == CLR && ok) evt_cnt <= evt_cnt + 8'd1;
      if (state == POLL && ok) flags <= prdata[1:0];
      if (state == IDLE && start) begin
        ld <= load_val;
        up <= cfg_up;
        cks <= cfg_cks;
        per <= periodic;
        stop_pend <= 1'b0;
        poll_cnt <= 8'h00;
        err <= 1'b0;
      end else if (state != IDLE && state != WR_STOP && stop) stop_pend <= 1'b1;
      if (state == POLL && ok && prdata[1:0] == 2'b00) poll_cnt <= poll_cnt + 8'd1;
      if (state == CLR && ok) poll_cnt <= 8'h00;
      if (done && pslverr) begin
        err <= 1'b1;
        err_addr <= paddr;
      end else if (timeout) begin
        err <= 1'b1;
        err_addr <= 8'hFF;
      end
    end
  end
  assign busy = state != IDLE;
  assign psel = xfer;
  assign penable = xfer && acc;
  assign pwrite = xfer && state != POLL;
  assign paddr = (state == POLL || state == CLR) ? 8'h02 :
                 (state == WR_LOAD || state == WR_RUN || state == WR_STOP) ? 8'h01 : 8'h00;
  // TCR layout: {load, 0, up, en, 00, cks}
  assign pwdata = state == WR_TDR  ? ld :
                  state == WR_LOAD ? {2'b10, up, 3'b000, cks} :
                  state == WR_RUN  ? {2'b00, up, 3'b100, cks} :
                  state == WR_STOP ? {2'b00, up, 3'b000, cks} :
                  state == CLR     ? {6'h3f, ~flags} : 8'h00;
endmodule

// File: doc/timer_apb_seq.md
TIMER_APB_SEQ -- requirements
Module: timer_apb_seq

Interface
REQ-001 SHALL provide parameter POLL_GAP, default 4: idle cycles between TSR polls (legal range 1..255).
REQ-002 SHALL provide parameter MAX_POLLS, default 255: polls without a flag before timeout (legal range 1..255).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 pclk  in  1  clock; all logic on rising edge.
REQ-005 preset  in  1  synchronous active-high reset.
REQ-006 start  in  1  one-cycle pulse; begins a run; honoured only in IDLE.
REQ-007 stop  in  1  one-cycle pulse; requests run termination.
REQ-008 load_val  in  8  timer reload value written to TDR.
REQ-009 cfg_up  in  1  count direction: 1 = up, 0 = down.
REQ-010 cfg_cks  in  2  timer clock select.
REQ-011 periodic  in  1  1 = keep polling after an event; 0 = stop after the first event.
REQ-012 psel, penable, pwrite  out  1 each  APB master controls.
REQ-013 paddr  out  8  APB address: 0x00 TDR, 0x01 TCR, 0x02 TSR.
REQ-014 pwdata  out  8  APB write data.
REQ-015 prdata  in  8  APB read data.
REQ-016 pready, pslverr  in  1 each  APB completion and error.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 evt_ovf, evt_udf  out  1 each  one-cycle event pulses.
REQ-019 err  out  1  sticky error; cleared by the next accepted start or by reset.
REQ-020 err_addr  out  8  paddr of the failing transfer; 0xFF for a timeout.
REQ-021 evt_cnt  out  8  number of reported events; wraps 0xFF -> 0x00.

Function
REQ-022 Each transfer SHALL take one SETUP cycle (psel=1, penable=0), then ACCESS cycles (psel=1, penable=1) until pready=1.
- The transfer completes on the edge where pready=1.
- paddr, pwdata and pwrite are held constant across SETUP and ACCESS.
REQ-023 Outside transfers, psel=penable=0 and pwrite=0.
REQ-024 The state machine SHALL have states IDLE, WR_TDR, WR_LOAD, WR_RUN, GAP, POLL, CLR, WR_STOP.
REQ-025 IDLE -> WR_TDR on start.
- start is ignored while busy=1.
- cfg_up, cfg_cks, load_val and periodic are latched at the accepted start.
REQ-026 WR_TDR writes addr 0x00 with the latched load_val.
REQ-027 WR_LOAD writes addr 0x01 with {1,0,up,0,00,cks}.
REQ-028 WR_RUN writes addr 0x01 with {0,0,up,1,00,cks}, then goes to GAP.
REQ-029 GAP counts POLL_GAP cycles, then goes to POLL.
REQ-030 POLL reads addr 0x02 and samples prdata[1:0] at completion.
- Result 00: poll counter increments; go to GAP, or to WR_STOP with timeout when the counter reaches MAX_POLLS.
- Result nonzero: go to CLR.
REQ-031 CLR writes addr 0x02 with {6'b111111, ~flags[1:0]}, clearing only the sampled flags.
REQ-032 At CLR completion:
- evt_ovf pulses if flags[0] was set; evt_udf pulses if flags[1] was set; both pulse in the same cycle if both were set.
- evt_cnt increments by 1 per CLR, not per bit.
- Poll counter resets to 0.
- Next state: GAP if periodic=1 and no stop is pending, else WR_STOP.
REQ-033 WR_STOP writes addr 0x01 with {0,0,up,0,00,cks} (en=0), then goes to IDLE.
REQ-034 stop pulse handling:
- During WR_TDR, WR_LOAD, WR_RUN, POLL or CLR: latched as pending; the current transfer completes.
- From GAP or POLL: the next state is WR_STOP.
- From CLR: the event is still reported, then WR_STOP.
REQ-035 A stop pulse in IDLE or WR_STOP SHALL be ignored.
REQ-036 pslverr=1 at completion of any transfer SHALL:
- set err and record err_addr;
- go directly to IDLE, with no further transfers (including WR_STOP);
- report no event for a CLR that errored.
REQ-037 Timeout SHALL set err, set err_addr=0xFF, then perform WR_STOP.
REQ-038 There is no APB timeout; an unbounded wait for pready is legal.

Reset
REQ-039 With preset=1 at an edge:
- state IDLE;
- psel, penable, pwrite, busy, evt_ovf, evt_udf, err = 0;
- paddr, pwdata, err_addr, evt_cnt = 0x00;
- poll counter, gap counter and stop-pending = 0.
REQ-040 Reset mid-transfer SHALL deassert psel and penable at that same edge; no transfer resumes afterwards.

Verification
REQ-041 Basic run: pready tied 1, start with load_val=0xF0, up=1, cks=2, periodic=0; prdata=0x01 on the 3rd poll.
- Required writes: (0x00,0xF0), (0x01,0xA2), (0x01,0x32), polls, (0x02,0xFE), (0x01,0x22).
- evt_ovf pulses once; evt_cnt=1; busy falls after the final write.
REQ-042 Wait states: pready low for 3 cycles on each transfer.
- penable stays high for 4 cycles per transfer.
- paddr and pwdata remain stable throughout.
REQ-043 Both flags: periodic=1, first poll returns 0x03.
- Required: CLR data 0xFC; evt_ovf and evt_udf pulse in the same cycle; evt_cnt=1; FSM returns to GAP.
REQ-044 Error: pslverr=1 on the WR_LOAD transfer.
- Required: err=1, err_addr=0x01, next state IDLE, no WR_STOP transfer.
- The next start clears err.
REQ-045 Stop and timeout:
- Stop pulse during GAP: next transfer is (0x01, en=0).
- MAX_POLLS=2 with all polls returning 0x00: err_addr=0xFF, then the WR_STOP write.
REQ-046 Reset asserted during the ACCESS phase of WR_RUN: psel=0 at the next edge; all outputs hold reset values.
